// File: rtl/fwd_ctrl_pkg.sv
// Shared constants for the EX-stage forwarding unit: operand-select codes,
// default register-file geometry and the hazard FSM state type.
package fwd_ctrl_pkg;

    localparam int unsigned DEF_REGW = 5;
    localparam int unsigned DEF_XZR  = 31;

    localparam logic [1:0] FWD_REG = 2'b00;
    localparam logic [1:0] FWD_MEM = 2'b01;
    localparam logic [1:0] FWD_WB  = 2'b10;

    typedef enum logic {
        RUN,
        STALL
    } state_e;

endpackage

// File: rtl/fwd_ctrl_cmp.sv
// One operand's forwarding select: picks the newest older writer of src
// (MEM before WB); the zero register is never forwarded.
module fwd_cmp
    import fwd_ctrl_pkg::*;
#(
    parameter int unsigned REGW = DEF_REGW,
    parameter int unsigned XZR  = DEF_XZR
) (
    input  logic [REGW-1:0] src,
    input  logic            used,
    input  logic            mem_valid,
    input  logic            mem_wreg,
    input  logic [REGW-1:0] mem_rd,
    input  logic            wb_valid,
    input  logic            wb_wreg,
    input  logic [REGW-1:0] wb_rd,
    output logic [1:0]      sel
);

    localparam logic [REGW-1:0] ZERO_IDX = REGW'(XZR);

    logic mem_hit;
    logic wb_hit;

    assign mem_hit = mem_valid && mem_wreg && (mem_rd != ZERO_IDX) && (mem_rd == src);
    assign wb_hit  = wb_valid  && wb_wreg  && (wb_rd  != ZERO_IDX) && (wb_rd  == src);

    always_comb begin
        sel = FWD_REG;
        if (used) begin
            if (mem_hit) begin
                sel = FWD_MEM;
            end else if (wb_hit) begin
                sel = FWD_WB;
            end
        end
    end

endmodule

// File: rtl/fwd_ctrl.sv
// EX/MEM/WB operand forwarding control with a one-cycle load-use interlock
// and a saturating stall-cycle counter.
module fwd_ctrl
    import fwd_ctrl_pkg::*;
#(
    parameter int unsigned REGW = DEF_REGW,
    parameter int unsigned XZR  = DEF_XZR
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            id_valid,
    input  logic [REGW-1:0] id_rn,
    input  logic [REGW-1:0] id_rm,
    input  logic            id_rn_used,
    input  logic            id_rm_used,
    input  logic [REGW-1:0] id_rd,
    input  logic            id_wreg,
    input  logic            id_is_load,
    input  logic            flush,
    output logic [1:0]      fwd_a,
    output logic [1:0]      fwd_b,
    output logic            stall,
    output logic [31:0]     stall_cnt
);

    localparam logic [REGW-1:0] ZERO_IDX = REGW'(XZR);

    typedef struct packed {
        logic            valid;
        logic [REGW-1:0] rn;
        logic [REGW-1:0] rm;
        logic            rn_used;
        logic            rm_used;
        logic [REGW-1:0] rd;
        logic            wreg;
        logic            is_load;
    } stage_t;

    stage_t ex_q, mem_q, wb_q;
    stage_t id_rec;
    state_e state_q, state_d;
    logic   ex_writes;
    logic   hazard;
    logic [1:0] sel_a, sel_b;

    assign id_rec = '{valid: id_valid, rn: id_rn, rm: id_rm, rn_used: id_rn_used,
                      rm_used: id_rm_used, rd: id_rd, wreg: id_wreg, is_load: id_is_load};

    assign ex_writes = ex_q.valid && ex_q.wreg && (ex_q.rd != ZERO_IDX);
    assign hazard    = id_valid && ex_q.is_load && ex_writes &&
                       ((id_rn_used && (id_rn == ex_q.rd)) || (id_rm_used && (id_rm == ex_q.rd)));

    // Gating with rst keeps outputs clean before the first reset edge lands.
    always_comb begin
        state_d = state_q;
        stall   = 1'b0;
        case (state_q)
            RUN: begin
                if (hazard && !flush && !rst) begin
                    stall   = 1'b1;
                    state_d = STALL;
                end
            end
            STALL: state_d = RUN;
            default: state_d = RUN;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            ex_q      <= '0;
            mem_q     <= '0;
            wb_q      <= '0;
            state_q   <= RUN;
            stall_cnt <= '0;
        end else begin
            wb_q    <= mem_q;
            mem_q   <= ex_q;
            ex_q    <= (stall || flush) ? '0 : id_rec;
            state_q <= state_d;
            if (stall && (stall_cnt != '1)) begin
                stall_cnt <= stall_cnt + 32'd1;
            end
        end
    end

    fwd_cmp #(.REGW(REGW), .XZR(XZR)) u_cmp_a (
        .src       (ex_q.rn),
        .used      (ex_q.rn_used),
        .mem_valid (mem_q.valid),
        .mem_wreg  (mem_q.wreg),
        .mem_rd    (mem_q.rd),
        .wb_valid  (wb_q.valid),
        .wb_wreg   (wb_q.wreg),
        .wb_rd     (wb_q.rd),
        .sel       (sel_a)
    );

    fwd_cmp #(.REGW(REGW), .XZR(XZR)) u_cmp_b (
        .src       (ex_q.rm),
        .used      (ex_q.rm_used),
        .mem_valid (mem_q.valid),
        .mem_wreg  (mem_q.wreg),
        .mem_rd    (mem_q.rd),
        .wb_valid  (wb_q.valid),
        .wb_wreg   (wb_q.wreg),
        .wb_rd     (wb_q.rd),
        .sel       (sel_b)
    );

    assign fwd_a = rst ? FWD_REG : sel_a;
    assign fwd_b = rst ? FWD_REG : sel_b;

endmodule

// File: tb/tb_fwd_ctrl.sv
// Bench for fwd_ctrl: directed forwarding/interlock scenarios followed by
// random instruction streams, all checked against an instruction-level model.
module tb_fwd_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        id_valid;
    logic [4:0]  id_rn, id_rm, id_rd;
    logic        id_rn_used, id_rm_used, id_wreg, id_is_load;
    logic        flush;
    logic [1:0]  fwd_a, fwd_b;
    logic        stall;
    logic [31:0] stall_cnt;

    always #5 clk = ~clk;

    fwd_ctrl #(.REGW(5), .XZR(31)) dut (
        .clk        (clk),
        .rst        (rst),
        .id_valid   (id_valid),
        .id_rn      (id_rn),
        .id_rm      (id_rm),
        .id_rn_used (id_rn_used),
        .id_rm_used (id_rm_used),
        .id_rd      (id_rd),
        .id_wreg    (id_wreg),
        .id_is_load (id_is_load),
        .flush      (flush),
        .fwd_a      (fwd_a),
        .fwd_b      (fwd_b),
        .stall      (stall),
        .stall_cnt  (stall_cnt)
    );

    typedef struct {
        bit v;
        int rn;
        int rm;
        bit rnu;
        bit rmu;
        int rd;
        bit w;
        bit ld;
    } ins_t;

    // Model: the three older instructions in flight, oldest last.
    ins_t        m_ex, m_mem, m_wb, idi;
    bit          flush_i, rst_i, exp_stall;
    logic [31:0] m_cnt;
    int          n_chk = 0;
    int          n_pass = 0;

    function automatic ins_t bubble();
        ins_t b;
        b = '{v: 0, rn: 0, rm: 0, rnu: 0, rmu: 0, rd: 0, w: 0, ld: 0};
        return b;
    endfunction

    function automatic ins_t mk(bit ld, int rd, bit w, int rn, bit rnu, int rm, bit rmu);
        ins_t i;
        i = '{v: 1, rn: rn, rm: rm, rnu: rnu, rmu: rmu, rd: rd, w: w, ld: ld};
        return i;
    endfunction

    function automatic bit produces(ins_t i, int r);
        return i.v && i.w && (i.rd != 31) && (i.rd == r);
    endfunction

    function automatic logic [1:0] want_sel(int src, bit used);
        if (!used) return 2'b00;
        if (produces(m_mem, src)) return 2'b01;
        if (produces(m_wb, src)) return 2'b10;
        return 2'b00;
    endfunction

    function automatic bit load_use();
        return idi.v && m_ex.ld &&
               ((idi.rnu && produces(m_ex, idi.rn)) || (idi.rmu && produces(m_ex, idi.rm)));
    endfunction

    function automatic int rreg();
        int t;
        t = $urandom_range(0, 4);
        return (t == 4) ? 31 : t;
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) n_pass++;
        else $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    endtask

    task automatic drive();
        rst        = rst_i;
        flush      = flush_i;
        id_valid   = idi.v;
        id_rn      = 5'(idi.rn);
        id_rm      = 5'(idi.rm);
        id_rd      = 5'(idi.rd);
        id_rn_used = idi.rnu;
        id_rm_used = idi.rmu;
        id_wreg    = idi.w;
        id_is_load = idi.ld;
    endtask

    // Drive, wait to mid-cycle, compare every output with the model.
    task automatic half();
        drive();
        @(negedge clk);
        exp_stall = !rst_i && load_use() && !flush_i;
        chk("fwd_a", {30'd0, fwd_a}, {30'd0, rst_i ? 2'b00 : want_sel(m_ex.rn, m_ex.rnu)});
        chk("fwd_b", {30'd0, fwd_b}, {30'd0, rst_i ? 2'b00 : want_sel(m_ex.rm, m_ex.rmu)});
        chk("stall", {31'd0, stall}, {31'd0, exp_stall});
        chk("stall_cnt", stall_cnt, m_cnt);
    endtask

    task automatic edge_();
        @(posedge clk);
        if (rst_i) begin
            m_ex  = bubble();
            m_mem = bubble();
            m_wb  = bubble();
            m_cnt = 32'd0;
        end else begin
            m_wb  = m_mem;
            m_mem = m_ex;
            m_ex  = (exp_stall || flush_i) ? bubble() : idi;
            if (exp_stall && m_cnt != 32'hFFFFFFFF) m_cnt = m_cnt + 32'd1;
        end
        #1;
    endtask

    task automatic issue(input ins_t i);
        idi = i;
        half();
        edge_();
    endtask

    task automatic drain();
        for (int k = 0; k < 3; k++) issue(bubble());
    endtask

    ins_t ldr3, use3;

    initial begin
        rst_i   = 1'b1;
        flush_i = 1'b0;
        idi     = bubble();
        m_ex    = bubble();
        m_mem   = bubble();
        m_wb    = bubble();
        m_cnt   = 32'd0;
        drive();
        @(posedge clk);
        #1;
        half();
        chk("reset_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("reset_stall", {31'd0, stall}, 32'd0);
        edge_();
        rst_i = 1'b0;
        drain();

        // ALU result one instruction back comes from MEM.
        issue(mk(0, 1, 1, 4, 1, 5, 1));
        issue(mk(0, 6, 1, 1, 1, 7, 0));
        idi = bubble();
        half();
        chk("add_fwd_a", {30'd0, fwd_a}, 32'd1);
        chk("add_stall", {31'd0, stall}, 32'd0);
        edge_();
        half();
        chk("add_fwd_a_gone", {30'd0, fwd_a}, 32'd0);
        edge_();
        drain();

        // Two back -> WB; two writers -> newest (MEM) wins.
        issue(mk(0, 2, 1, 0, 0, 0, 0));
        issue(mk(0, 9, 1, 0, 0, 0, 0));
        issue(mk(0, 10, 1, 0, 0, 2, 1));
        idi = bubble();
        half();
        chk("x2_wb_fwd_b", {30'd0, fwd_b}, 32'd2);
        edge_();
        drain();
        issue(mk(0, 2, 1, 0, 0, 0, 0));
        issue(mk(0, 2, 1, 0, 0, 0, 0));
        issue(mk(0, 10, 1, 0, 0, 2, 1));
        idi = bubble();
        half();
        chk("x2_both_fwd_b", {30'd0, fwd_b}, 32'd1);
        edge_();
        drain();

        // Load-use: one stall cycle, then load value from WB.
        ldr3 = mk(1, 3, 1, 0, 0, 0, 0);
        use3 = mk(0, 11, 1, 3, 1, 0, 0);
        issue(ldr3);
        idi = use3;
        half();
        chk("ldu_stall", {31'd0, stall}, 32'd1);
        chk("ldu_cnt0", stall_cnt, 32'd0);
        edge_();
        half();
        chk("ldu_stall_once", {31'd0, stall}, 32'd0);
        chk("ldu_cnt1", stall_cnt, 32'd1);
        edge_();
        idi = bubble();
        half();
        chk("ldu_fwd_a", {30'd0, fwd_a}, 32'd2);
        edge_();
        drain();

        // Zero register is never forwarded.
        issue(mk(0, 31, 1, 0, 0, 0, 0));
        issue(mk(0, 12, 1, 31, 1, 31, 1));
        idi = bubble();
        half();
        chk("xzr_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("xzr_fwd_b", {30'd0, fwd_b}, 32'd0);
        edge_();
        drain();

        // Flush beats the load-use hazard.
        issue(ldr3);
        idi     = use3;
        flush_i = 1'b1;
        half();
        chk("flush_stall", {31'd0, stall}, 32'd0);
        edge_();
        flush_i = 1'b0;
        idi     = bubble();
        half();
        chk("flush_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("flush_fwd_b", {30'd0, fwd_b}, 32'd0);
        chk("flush_cnt", stall_cnt, 32'd1);
        edge_();
        drain();

        // Reset while in the stall cycle.
        issue(ldr3);
        idi = use3;
        half();
        chk("rst_pre_stall", {31'd0, stall}, 32'd1);
        edge_();
        rst_i = 1'b1;
        half();
        edge_();
        rst_i = 1'b0;
        idi   = bubble();
        half();
        chk("rst_stall", {31'd0, stall}, 32'd0);
        chk("rst_cnt", stall_cnt, 32'd0);
        chk("rst_fwd_a", {30'd0, fwd_a}, 32'd0);
        chk("rst_fwd_b", {30'd0, fwd_b}, 32'd0);
        edge_();

        // Random streams; a stalled instruction is held in ID.
        for (int n = 0; n < 600; n++) begin
            if (!exp_stall || rst_i) begin
                idi = mk($urandom_range(0, 9) < 3, rreg(), $urandom_range(0, 4) != 0,
                         rreg(), $urandom_range(0, 3) != 0, rreg(), $urandom_range(0, 3) != 0);
                idi.v = ($urandom_range(0, 7) != 0);
            end
            flush_i = ($urandom_range(0, 9) == 0);
            rst_i   = ($urandom_range(0, 99) == 0);
            half();
            edge_();
        end

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
